// File: rtl/clock_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_meter_pkg
// Brief    : Shared types and default constants for the clock period meter.
// Revision : 1.0 - initial release
// ============================================================================
package clock_meter_pkg;

  // Default counter width and timeout (one second at a 200 MHz clock_in).
  localparam int                             c_DEFAULT_CNT_WIDTH   = 28;
  localparam logic [c_DEFAULT_CNT_WIDTH-1:0] c_DEFAULT_TIMEOUT     = 28'd200000000;
  localparam int                             c_DEFAULT_SYNC_STAGES = 2;

  // Meter state: waiting for an arming edge, or counting an interval.
  typedef enum logic [0:0] {
    WAIT_EDGE = 1'b0,
    COUNT     = 1'b1
  } meter_state_t;

endpackage : clock_meter_pkg
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : edge_sync
// Brief    : Multi-flop synchroniser for an asynchronous slow input, plus a
//            previous-value register producing single-cycle rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // r_sync[0] is the metastability-exposed flop; the last stage is the clean level.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;

  // Shift the async input through the synchroniser chain and keep the previous level.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_level_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = level & ~r_level_d;
  assign fall  = ~level & r_level_d;

endmodule : edge_sync
`default_nettype wire

// File: rtl/clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : clock_period_meter
// Brief    : Measures period and high time of a slow square wave in clock_in
//            cycles, and raises a sticky timeout when the input stops toggling.
// Revision : 1.0 - initial release
// ============================================================================
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int                   CNT_WIDTH   = c_DEFAULT_CNT_WIDTH,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT     = c_DEFAULT_TIMEOUT,
  parameter int                   SYNC_STAGES = c_DEFAULT_SYNC_STAGES
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] c_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic w_level;
  logic w_rise;
  logic w_fall;

  meter_state_t r_state;
  meter_state_t w_state_nxt;

  // r_cnt counts cycles since the last rise, r_hcnt counts the high cycles of
  // that interval; r_hlatch captures r_hcnt at the fall so the high time of a
  // finished interval survives the low phase.
  logic [CNT_WIDTH-1:0] r_cnt,       w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_hcnt,      w_hcnt_nxt;
  logic [CNT_WIDTH-1:0] r_hlatch,    w_hlatch_nxt;
  logic [CNT_WIDTH-1:0] r_period,    w_period_nxt;
  logic [CNT_WIDTH-1:0] r_high_time, w_high_time_nxt;
  logic                 r_fall_seen, w_fall_seen_nxt;
  logic                 r_meas_valid, w_meas_valid_nxt;
  logic                 r_timeout,   w_timeout_nxt;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .sig_in   (sig_in),
    .level    (w_level),
    .rise     (w_rise),
    .fall     (w_fall)
  );

  // Next-state and datapath decisions; everything holds unless a branch updates it.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_hcnt_nxt       = r_hcnt;
    w_hlatch_nxt     = r_hlatch;
    w_fall_seen_nxt  = r_fall_seen;
    w_period_nxt     = r_period;
    w_high_time_nxt  = r_high_time;
    w_meas_valid_nxt = 1'b0;
    w_timeout_nxt    = r_timeout;

    case (r_state)
      WAIT_EDGE: begin
        // The first rise only arms the meter; no measurement is reported.
        if (w_rise) begin
          w_cnt_nxt       = c_ONE;
          w_hcnt_nxt      = c_ONE;
          w_fall_seen_nxt = 1'b0;
          w_state_nxt     = COUNT;
        end
      end

      COUNT: begin
        if (w_rise) begin
          // Interval closed: report it and start the next one immediately.
          w_period_nxt     = r_cnt;
          w_high_time_nxt  = r_fall_seen ? r_hlatch : r_cnt;
          w_meas_valid_nxt = 1'b1;
          w_timeout_nxt    = 1'b0;
          w_cnt_nxt        = c_ONE;
          w_hcnt_nxt       = c_ONE;
          w_fall_seen_nxt  = 1'b0;
        end else if (r_cnt == TIMEOUT) begin
          // Input has stalled; counters stop here so they can never wrap.
          w_timeout_nxt = 1'b1;
          w_state_nxt   = WAIT_EDGE;
        end else begin
          w_cnt_nxt = r_cnt + c_ONE;
          if (w_level) begin
            w_hcnt_nxt = r_hcnt + c_ONE;
          end
          if (w_fall) begin
            w_hlatch_nxt    = r_hcnt;
            w_fall_seen_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = WAIT_EDGE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state <= WAIT_EDGE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter and output registers.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_hlatch     <= '0;
      r_fall_seen  <= 1'b0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_hlatch     <= w_hlatch_nxt;
      r_fall_seen  <= w_fall_seen_nxt;
      r_period     <= w_period_nxt;
      r_high_time  <= w_high_time_nxt;
      r_meas_valid <= w_meas_valid_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign period     = r_period;
  assign high_time  = r_high_time;
  assign meas_valid = r_meas_valid;
  assign timeout    = r_timeout;

endmodule : clock_period_meter
`default_nettype wire
